rom_ctrl_check_seq: RTL and testbench
=====================================

# rom_ctrl_check_seq

Sequencer for the ROM integrity check. It paces the address counter against KMAC back-pressure and streams the non-top ROM words to KMAC. It captures the top RomTopCount words as the expected digest, compares that against the KMAC digest, and then hands ROM access to the bus. It sits between the address counter, the ROM output buffer, the KMAC application interface and the ROM access mux.

## Interface
Parameters:
- RomDepth, 16, ROM depth in words; AW = vbits(RomDepth)
- RomTopCount, 2, number of top words that hold the expected digest
- DW, 32, ROM word width; the digest width is DW*RomTopCount

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- cnt_done_i  in  1  counter reached the top of ROM
- cnt_data_addr_i  in  AW  address of the word currently on rom_rdata_i
- cnt_last_nontop_i  in  1  current word is the last non-top word
- cnt_data_rdy_o  out  1  advance the counter (combinational)
- rom_rdata_i  in  DW  ROM output buffer
- kmac_data_o  out  DW  word to hash; equals rom_rdata_i
- kmac_valid_o  out  1  kmac_data_o is valid
- kmac_last_o  out  1  final word of the message
- kmac_ready_i  in  1  KMAC accepts the word
- kmac_done_i  in  1  KMAC digest is valid (single-cycle pulse)
- kmac_digest_i  in  DW*RomTopCount  computed digest
- exp_digest_o  out  DW*RomTopCount  captured expected digest
- bus_sel_o  out  1  ROM mux selects the bus (registered)
- done_o  out  1  check finished (registered)
- good_o  out  1  digests matched; valid when done_o=1
- alert_o  out  1  fatal sequencing error (registered, sticky)

## Operation
- vld_q: 0 in reset, 1 from the first cycle after reset. ROM data is valid one cycle after the first request.
- States:
  - ReadNonTop (reset state)
  - ReadTop
  - WaitDigest
  - Compare
  - Done
  - Invalid
- ReadNonTop:
  - kmac_valid_o = vld_q
  - kmac_last_o = cnt_last_nontop_i
  - cnt_data_rdy_o = kmac_ready_i
  - On a handshake (valid & ready & last) go to ReadTop.
- ReadTop:
  - kmac_valid_o = 0; cnt_data_rdy_o = 1.
  - Each cycle, write rom_rdata_i into exp slot (cnt_data_addr_i - (RomDepth-RomTopCount)). The subtraction is AW-bit; slots outside range are ignored. Slot 0 is the LSBs.
  - When cnt_done_i=1, perform the final capture and go to WaitDigest.
- WaitDigest:
  - cnt_data_rdy_o = 0.
  - On kmac_done_i, latch kmac_digest_i and go to Compare.
- Compare: good_q <= (digest_q == exp_q); go to Done.
- Done: terminal; done_o=1, bus_sel_o=1.
- Invalid: terminal until reset. All handshake outputs are 0, bus_sel_o=0, done_o=0, good_o=0, alert_o=1.
- Error transitions to Invalid, from any state:
  - kmac_done_i while in ReadNonTop or ReadTop
  - cnt_done_i falls after it was seen high
  - an illegal state encoding
- Simultaneous events:
  - The last non-top handshake together with kmac_done_i goes to Invalid.
  - cnt_done_i together with a capture in ReadTop captures, then transitions.
- Reset mid-operation restarts from ReadNonTop and clears exp_q, digest_q and good_q.

## Timing
- Reset values: cnt_data_rdy_o=0, kmac_valid_o=0, kmac_last_o=0, kmac_data_o=rom_rdata_i, exp_digest_o=0, bus_sel_o=0, done_o=0, good_o=0, alert_o=0.
- Handshake rules:
  - kmac_valid_o never drops without ready, except on a transition to Invalid.
  - kmac_data_o and kmac_last_o stay stable while valid & !ready.
- Latency:
  - kmac_done_i to Compare: 1 cycle.
  - done_o, bus_sel_o and good_o are registered together: 2 cycles after kmac_done_i.
  - alert_o asserts 1 cycle after the error condition.
- bus_sel_o never transitions 1 to 0 except on reset.

## Structure
- Package rom_ctrl_check_seq_pkg:
  - State enum, 6-bit sparse encoding with minimum Hamming distance 3. Every non-listed value decodes to Invalid.
  - Localparams NonTopCount and DigestW.
- Sub-module rom_ctrl_exp_digest holds the RomTopCount x DW capture bank with slot-write decode.
- The counter stays external.

## Test plan
- Default parameters, kmac_ready_i=1 throughout, kmac_digest_i equal to ROM words 14,15:
  - 14 words are accepted, with last on address 13.
  - exp_digest_o = {w15,w14}.
  - After kmac_done_i: good_o=1, done_o=1, bus_sel_o=1 two cycles later.
- Same as the first scenario, but kmac_digest_i with bit 0 flipped -> done_o=1, good_o=0, bus_sel_o=1.
- kmac_ready_i toggled 0/1 every cycle -> data and last stay stable while stalled; the counter advances only on accepted words; exactly 14 accepted.
- kmac_done_i pulsed while at address 5 -> alert_o=1 the next cycle; valid and rdy go to 0; bus_sel_o stays 0.
- cnt_done_i dropped for one cycle in WaitDigest -> Invalid, alert_o=1, and it persists until reset.
- rst_ni asserted mid ReadTop:
  - Outputs return to their reset values immediately (asynchronous reset).
  - After release, the full sequence completes correctly.

Source files
------------

// File: rtl/rom_ctrl_check_seq_pkg.sv
// rtl/rom_ctrl_check_seq_pkg.sv - shared types and defaults for the ROM check sequencer
package rom_ctrl_check_seq_pkg;

    localparam int DefRomDepth    = 16;
    localparam int DefRomTopCount = 2;
    localparam int DefDW          = 32;
    localparam int NonTopCount    = DefRomDepth - DefRomTopCount;
    localparam int DigestW        = DefDW * DefRomTopCount;

    // Codes are words of a [6,3,3] linear code: any single-bit upset lands on an unlisted value.
    typedef enum logic [5:0] {
        StReadNonTop = 6'b100110,
        StReadTop    = 6'b010101,
        StWaitDigest = 6'b001011,
        StCompare    = 6'b110011,
        StDone       = 6'b101101,
        StInvalid    = 6'b011110
    } state_e;

endpackage

// File: rtl/rom_ctrl_exp_digest.sv
// rtl/rom_ctrl_exp_digest.sv - capture bank for the expected digest held in the top ROM words
module rom_ctrl_exp_digest #(
    parameter int  RomDepth    = 16,
    parameter int  RomTopCount = 2,
    parameter int  DW          = 32,
    localparam int AW          = (RomDepth > 1) ? $clog2(RomDepth) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      we_i,
    input  logic [AW-1:0]             addr_i,
    input  logic [DW-1:0]             wdata_i,
    output logic [DW*RomTopCount-1:0] exp_o
);

    localparam logic [AW-1:0] Base = AW'(RomDepth - RomTopCount);

    logic [AW-1:0]                     slot;
    logic [RomTopCount-1:0][DW-1:0]    bank_q, bank_d;

    // Wrapping subtraction: addresses below the top region give large slots that match nothing.
    assign slot  = addr_i - Base;
    assign exp_o = bank_q;

    always_comb begin
        bank_d = bank_q;
        for (int i = 0; i < RomTopCount; i++) begin
            if (we_i && (slot == AW'(i))) begin
                bank_d[i] = wdata_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bank_q <= '0;
        end else begin
            bank_q <= bank_d;
        end
    end

endmodule

// File: rtl/rom_ctrl_check_seq.sv
// rtl/rom_ctrl_check_seq.sv - ROM integrity check sequencer: streams ROM to KMAC, compares digests
module rom_ctrl_check_seq
    import rom_ctrl_check_seq_pkg::*;
#(
    parameter int  RomDepth    = DefRomDepth,
    parameter int  RomTopCount = DefRomTopCount,
    parameter int  DW          = DefDW,
    localparam int AW          = (RomDepth > 1) ? $clog2(RomDepth) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      cnt_done_i,
    input  logic [AW-1:0]             cnt_data_addr_i,
    input  logic                      cnt_last_nontop_i,
    output logic                      cnt_data_rdy_o,
    input  logic [DW-1:0]             rom_rdata_i,
    output logic [DW-1:0]             kmac_data_o,
    output logic                      kmac_valid_o,
    output logic                      kmac_last_o,
    input  logic                      kmac_ready_i,
    input  logic                      kmac_done_i,
    input  logic [DW*RomTopCount-1:0] kmac_digest_i,
    output logic [DW*RomTopCount-1:0] exp_digest_o,
    output logic                      bus_sel_o,
    output logic                      done_o,
    output logic                      good_o,
    output logic                      alert_o
);

    state_e                    state_q, state_d;
    logic                      vld_q, vld_d;
    logic                      cnt_done_seen_q, cnt_done_seen_d;
    logic [DW*RomTopCount-1:0] digest_q, digest_d;
    logic                      good_q, good_d;
    logic                      done_q, done_d;
    logic                      bus_sel_q, bus_sel_d;
    logic                      alert_q, alert_d;
    logic                      exp_we;

    rom_ctrl_exp_digest #(
        .RomDepth    (RomDepth),
        .RomTopCount (RomTopCount),
        .DW          (DW)
    ) u_exp_digest (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (exp_we),
        .addr_i  (cnt_data_addr_i),
        .wdata_i (rom_rdata_i),
        .exp_o   (exp_digest_o)
    );

    assign kmac_data_o = rom_rdata_i;
    assign bus_sel_o   = bus_sel_q;
    assign done_o      = done_q;
    assign good_o      = good_q;
    assign alert_o     = alert_q;

    always_comb begin
        state_d         = state_q;
        vld_d           = 1'b1;
        cnt_done_seen_d = cnt_done_seen_q | cnt_done_i;
        digest_d        = digest_q;
        good_d          = good_q;
        exp_we          = 1'b0;
        kmac_valid_o    = 1'b0;
        kmac_last_o     = 1'b0;
        cnt_data_rdy_o  = 1'b0;

        case (state_q)
            StReadNonTop: begin
                // Nothing is offered or advanced until the first ROM word is valid.
                kmac_valid_o   = vld_q;
                kmac_last_o    = vld_q & cnt_last_nontop_i;
                cnt_data_rdy_o = vld_q & kmac_ready_i;
                if (vld_q && kmac_ready_i && cnt_last_nontop_i) begin
                    state_d = StReadTop;
                end
            end
            StReadTop: begin
                cnt_data_rdy_o = 1'b1;
                exp_we         = 1'b1;
                if (cnt_done_i) begin
                    state_d = StWaitDigest;
                end
            end
            StWaitDigest: begin
                if (kmac_done_i) begin
                    digest_d = kmac_digest_i;
                    state_d  = StCompare;
                end
            end
            StCompare: begin
                good_d  = (digest_q == exp_digest_o);
                state_d = StDone;
            end
            StDone, StInvalid: begin
            end
            default: state_d = StInvalid;
        endcase

        // Done is excluded so the bus grant can never be withdrawn once given.
        if ((state_q inside {StReadNonTop, StReadTop}) && kmac_done_i) begin
            state_d = StInvalid;
        end
        if (!(state_q inside {StDone, StInvalid}) && cnt_done_seen_q && !cnt_done_i) begin
            state_d = StInvalid;
        end

        done_d    = (state_d == StDone);
        bus_sel_d = (state_d == StDone);
        alert_d   = (state_d == StInvalid);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= StReadNonTop;
            vld_q           <= 1'b0;
            cnt_done_seen_q <= 1'b0;
            digest_q        <= '0;
            good_q          <= 1'b0;
            done_q          <= 1'b0;
            bus_sel_q       <= 1'b0;
            alert_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            vld_q           <= vld_d;
            cnt_done_seen_q <= cnt_done_seen_d;
            digest_q        <= digest_d;
            good_q          <= good_d;
            done_q          <= done_d;
            bus_sel_q       <= bus_sel_d;
            alert_q         <= alert_d;
        end
    end

endmodule

// File: tb/tb_rom_ctrl_check_seq.sv
// tb/tb_rom_ctrl_check_seq.sv - scoreboard bench for rom_ctrl_check_seq
module tb_rom_ctrl_check_seq;

    localparam logic [63:0] GoodDigest = 64'h1F0F0F0F_1E0E0E0E;
    localparam logic [63:0] BadDigest  = 64'h1F0F0F0F_1E0E0E0F;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  addr;
    logic        tb_vld;
    logic        drop_done;
    logic [31:0] rom [16];

    logic        cnt_done, cnt_last, cnt_rdy;
    logic [31:0] rom_rdata, kmac_data;
    logic        kmac_valid, kmac_last, kmac_ready, kmac_done;
    logic [63:0] kmac_digest, exp_digest;
    logic        bus_sel, done, good, alert;

    int          total = 0;
    int          bad   = 0;
    int          acc_cnt = 0;
    logic [32:0] word_q [$];
    logic [64:0] res_q [$];

    always #5 clk = ~clk;

    // Counter and ROM buffer model: data valid one cycle after reset, stops at the top word.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr   <= 4'd0;
            tb_vld <= 1'b0;
        end else begin
            tb_vld <= 1'b1;
            if (tb_vld && cnt_rdy && addr != 4'd15) addr <= addr + 4'd1;
        end
    end

    assign cnt_done  = (addr == 4'd15) && !drop_done;
    assign cnt_last  = (addr == 4'd13);
    assign rom_rdata = rom[addr];

    rom_ctrl_check_seq dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .cnt_done_i        (cnt_done),
        .cnt_data_addr_i   (addr),
        .cnt_last_nontop_i (cnt_last),
        .cnt_data_rdy_o    (cnt_rdy),
        .rom_rdata_i       (rom_rdata),
        .kmac_data_o       (kmac_data),
        .kmac_valid_o      (kmac_valid),
        .kmac_last_o       (kmac_last),
        .kmac_ready_i      (kmac_ready),
        .kmac_done_i       (kmac_done),
        .kmac_digest_i     (kmac_digest),
        .exp_digest_o      (exp_digest),
        .bus_sel_o         (bus_sel),
        .done_o            (done),
        .good_o            (good),
        .alert_o           (alert)
    );

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) word_q.push_back({1'(i == 13), rom[i]});
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rdy"},   cnt_rdy, 0);
        check({tag, "_valid"}, kmac_valid, 0);
        check({tag, "_last"},  kmac_last, 0);
        check({tag, "_data"},  kmac_data, 32'h1000_0000);
        check({tag, "_exp"},   exp_digest, 0);
        check({tag, "_bus"},   bus_sel, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_good"},  good, 0);
        check({tag, "_alert"}, alert, 0);
    endtask

    task automatic do_reset();
        kmac_ready  = 1'b0;
        kmac_done   = 1'b0;
        drop_done   = 1'b0;
        kmac_digest = '0;
        rst_n       = 1'b0;
        acc_cnt     = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic run_stream(input bit toggle, input string tag);
        bit got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(posedge clk);
            #1 kmac_ready = toggle ? ~kmac_ready : 1'b1;
            @(negedge clk);
            if (kmac_valid && kmac_ready && kmac_last) got = 1'b1;
        end
        kmac_ready = 1'b1;
        check({tag, "_last_seen"}, got, 1);
    endtask

    task automatic pulse_done(input logic [63:0] dig, input string tag);
        repeat (4) @(posedge clk);
        #1 kmac_digest = dig;
        kmac_done = 1'b1;
        @(posedge clk);
        #1 kmac_done = 1'b0;
        @(negedge clk);
        check({tag, "_done_early"}, done, 0);
        @(negedge clk);
        check({tag, "_done_lat"}, done, 1);
        check({tag, "_bus_lat"}, bus_sel, 1);
        repeat (3) @(negedge clk);
        check({tag, "_done_hold"}, done, 1);
        check({tag, "_bus_hold"}, bus_sel, 1);
    endtask

    // Monitor: pops accepted words and final results, and checks stall stability.
    initial begin
        logic        prev_stall;
        logic [32:0] prev_w;
        logic        done_prev;
        logic [32:0] w;
        logic [64:0] r;
        prev_stall = 1'b0;
        prev_w     = '0;
        done_prev  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                prev_stall = 1'b0;
                done_prev  = 1'b0;
            end else begin
                if (prev_stall && !alert) begin
                    check("stall_valid", kmac_valid, 1);
                    check("stall_word", {kmac_last, kmac_data}, prev_w);
                end
                if (kmac_valid && !kmac_ready) check("stall_rdy", cnt_rdy, 0);
                if (kmac_valid && kmac_ready) begin
                    acc_cnt++;
                    if (word_q.size() == 0) begin
                        check("unexpected_word", {kmac_last, kmac_data}, 0);
                    end else begin
                        w = word_q.pop_front();
                        check("word", {kmac_last, kmac_data}, w);
                    end
                end
                if (done && !done_prev) begin
                    if (res_q.size() == 0) begin
                        check("unexpected_done", done, 0);
                    end else begin
                        r = res_q.pop_front();
                        check("good", good, r[64]);
                        check("bus_sel", bus_sel, 1);
                        check("exp_digest", exp_digest, r[63:0]);
                    end
                end
                prev_stall = kmac_valid && !kmac_ready;
                prev_w     = {kmac_last, kmac_data};
                done_prev  = done;
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 32'(32'h1000_0000 + i * 32'h0101_0101);
        rst_n       = 1'b1;
        kmac_ready  = 1'b0;
        kmac_done   = 1'b0;
        drop_done   = 1'b0;
        kmac_digest = '0;
        #1 rst_n = 1'b0;
        #1 check_reset_vals("rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Matching digest
        push_words(14);
        res_q.push_back({1'b1, GoodDigest});
        run_stream(1'b0, "s1");
        pulse_done(GoodDigest, "s1");
        check("s1_accepted", acc_cnt, 14);

        // Digest with bit 0 flipped
        do_reset();
        push_words(14);
        res_q.push_back({1'b0, GoodDigest});
        run_stream(1'b0, "s2");
        pulse_done(BadDigest, "s2");
        check("s2_accepted", acc_cnt, 14);

        // Back-pressure toggling every cycle
        do_reset();
        push_words(14);
        res_q.push_back({1'b1, GoodDigest});
        run_stream(1'b1, "s3");
        pulse_done(GoodDigest, "s3");
        check("s3_accepted", acc_cnt, 14);

        // kmac_done while streaming address 5
        do_reset();
        kmac_ready = 1'b1;
        push_words(6);
        begin
            bit hit = 1'b0;
            for (int c = 0; c < 50 && !hit; c++) begin
                @(posedge clk);
                #1 if (addr == 4'd5) begin
                    kmac_done = 1'b1;
                    hit = 1'b1;
                end
            end
            check("s4_addr5_seen", hit, 1);
        end
        @(posedge clk);
        #1 kmac_done = 1'b0;
        @(negedge clk);
        check("s4_alert", alert, 1);
        check("s4_valid", kmac_valid, 0);
        check("s4_rdy", cnt_rdy, 0);
        check("s4_bus", bus_sel, 0);
        repeat (5) @(negedge clk);
        check("s4_alert_hold", alert, 1);
        check("s4_bus_hold", bus_sel, 0);
        check("s4_accepted", acc_cnt, 6);

        // cnt_done dropped for one cycle while waiting for the digest
        do_reset();
        push_words(14);
        run_stream(1'b0, "s5");
        repeat (4) @(posedge clk);
        #1 drop_done = 1'b1;
        @(posedge clk);
        #1 drop_done = 1'b0;
        @(negedge clk);
        check("s5_alert", alert, 1);
        check("s5_valid", kmac_valid, 0);
        check("s5_rdy", cnt_rdy, 0);
        repeat (6) @(negedge clk);
        check("s5_alert_hold", alert, 1);
        check("s5_done", done, 0);
        check("s5_bus", bus_sel, 0);

        // Reset in the middle of the top-word capture
        do_reset();
        push_words(14);
        run_stream(1'b0, "s6");
        repeat (2) @(posedge clk);
        #1 check("s6_partial_exp", exp_digest[31:0], 32'h1E0E0E0E);
        rst_n = 1'b0;
        #1 check_reset_vals("s6_rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        acc_cnt = 0;
        push_words(14);
        res_q.push_back({1'b1, GoodDigest});
        run_stream(1'b0, "s6b");
        pulse_done(GoodDigest, "s6b");
        check("s6_accepted", acc_cnt, 14);

        check("words_left", word_q.size(), 0);
        check("results_left", res_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
